// File: rtl/dac_comp_sweep.sv
// dac_comp_sweep: sweeps a first-order sigma-delta DAC code and reports the first comparator flip.
// Define DAC_COMP_SWEEP_AVG_EN for a 3-capture majority-vote SAMPLE phase.
module dac_comp_sweep #(
  parameter int WIDTH  = 8,
  parameter int CH     = 2,
  parameter int SETTLE = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [$clog2(CH)-1:0] ch_sel,
  input  logic [WIDTH-1:0]      code_lo,
  input  logic [WIDTH-1:0]      code_hi,
  input  logic [CH-1:0]         cmp_in,
  output logic [CH-1:0]         dac_p,
  output logic [CH-1:0]         dac_m,
  output logic                  busy,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [WIDTH-1:0]      res_code,
  output logic                  res_found
);
  localparam int SW = $clog2(CH);
  localparam int CW = $clog2(SETTLE + 1);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_REPORT} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] code, hi_q, acc;
  logic [WIDTH:0]   sum;
  logic [SW-1:0]    sel_q;
  logic             up, first, ref_q;
  logic             active, sel_ok, d_raw, d, smp_last, trip, at_hi;

  assign active = (state == S_SETTLE) || (state == S_SAMPLE);
  assign sel_ok = (32'(ch_sel) < CH);
  assign d_raw  = cmp_in[sel_q];
  assign trip   = !first && (d != ref_q);
  assign at_hi  = (code == hi_q);
  assign busy      = (state != S_IDLE);
  assign res_valid = (state == S_REPORT);

`ifdef DAC_COMP_SWEEP_AVG_EN
  logic [1:0] smp_cnt;
  logic [1:0] cap;

  assign smp_last = (smp_cnt == 2'd2);
  // Majority of the two stored captures and the live third one.
  assign d = (cap[0] & cap[1]) | (cap[0] & d_raw) | (cap[1] & d_raw);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      smp_cnt <= 2'd0;
      cap     <= 2'b00;
    end else if (state == S_SAMPLE) begin
      smp_cnt <= smp_last ? 2'd0 : smp_cnt + 2'd1;
      if (!smp_last) cap[smp_cnt[0]] <= d_raw;
    end else begin
      smp_cnt <= 2'd0;
    end
  end
`else
  assign smp_last = 1'b1;
  assign d        = d_raw;
`endif

  // Carry out of acc + code is the bitstream; density is code / 2^WIDTH.
  assign sum = {1'b0, acc} + {1'b0, code};

  always_comb begin
    dac_p = '0;
    dac_m = '0;
    if (active) begin
      dac_p[sel_q] = sum[WIDTH];
      dac_m[sel_q] = ~sum[WIDTH];
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = sel_ok ? S_SETTLE : S_REPORT;
      S_SETTLE: if (cnt == CW'(SETTLE - 1)) state_nxt = S_SAMPLE;
      S_SAMPLE: if (smp_last) state_nxt = (trip || at_hi) ? S_REPORT : S_SETTLE;
      S_REPORT: if (res_ready) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      code      <= '0;
      hi_q      <= '0;
      acc       <= '0;
      sel_q     <= '0;
      up        <= 1'b0;
      first     <= 1'b0;
      ref_q     <= 1'b0;
      res_code  <= '0;
      res_found <= 1'b0;
    end else begin
      state <= state_nxt;
      if (active) acc <= sum[WIDTH-1:0];
      case (state)
        S_IDLE: if (start) begin
          code  <= code_lo;
          hi_q  <= code_hi;
          up    <= (code_lo <= code_hi);
          sel_q <= ch_sel;
          first <= 1'b1;
          cnt   <= '0;
          acc   <= '0;
          if (!sel_ok) begin
            res_code  <= code_lo;
            res_found <= 1'b0;
          end
        end
        S_SETTLE: cnt <= cnt + CW'(1);
        S_SAMPLE: if (smp_last) begin
          cnt   <= '0;
          first <= 1'b0;
          if (first) ref_q <= d;
          if (trip) begin
            res_found <= 1'b1;
            res_code  <= code;
          end else if (at_hi) begin
            res_found <= 1'b0;
            res_code  <= hi_q;
          end else begin
            code <= up ? code + WIDTH'(1) : code - WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_dac_comp_sweep.sv
// Bench for dac_comp_sweep: cycle-indexed sweep model plus hand-computed latency/result literals.
module tb_dac_comp_sweep;
`ifdef DAC_COMP_SWEEP_AVG_EN
  localparam int SL = 3;
`else
  localparam int SL = 1;
`endif
  localparam int STEP = 4 + SL;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] lo = 8'h00, hi = 8'h00;

  logic       a_start = 1'b0, a_ready = 1'b0;
  logic [0:0] a_sel = 1'b0;
  logic [1:0] a_cmp = 2'b00, a_p, a_m;
  logic       a_busy, a_valid, a_found;
  logic [7:0] a_code;

  logic       b_start = 1'b0, b_ready = 1'b0;
  logic [1:0] b_sel = 2'd0;
  logic [2:0] b_cmp = 3'b000, b_p, b_m;
  logic       b_busy, b_valid, b_found;
  logic [7:0] b_code;

  int total = 0, bad = 0;

  always #5 clk = ~clk;

  dac_comp_sweep u_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .ch_sel(a_sel), .code_lo(lo), .code_hi(hi),
    .cmp_in(a_cmp), .dac_p(a_p), .dac_m(a_m), .busy(a_busy), .res_valid(a_valid),
    .res_ready(a_ready), .res_code(a_code), .res_found(a_found));

  dac_comp_sweep #(.WIDTH(8), .CH(3), .SETTLE(256)) u_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .ch_sel(b_sel), .code_lo(lo), .code_hi(hi),
    .cmp_in(b_cmp), .dac_p(b_p), .dac_m(b_m), .busy(b_busy), .res_valid(b_valid),
    .res_ready(b_ready), .res_code(b_code), .res_found(b_found));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Sweep model: comparator law, trip step and resulting latency from plain arithmetic.
  int m_lo, m_dir, m_sel, m_mode, m_thr, m_gl, m_L, m_res, m_tot, cyc;
  bit m_found;

  function automatic bit dmod(input int c);
    return (m_mode != 0) && (c >= m_thr);
  endfunction

  task automatic model_setup(input int l, input int h, input int sel, input int mode,
                             input int thr, input int gl);
    int n, k;
    bit rf;
    m_lo = l; m_sel = sel; m_mode = mode; m_thr = thr; m_gl = gl; m_tot = 0;
    m_dir = (l <= h) ? 1 : -1;
    n = (l <= h) ? h - l + 1 : l - h + 1;
    rf = dmod(l);
    m_found = 0; m_res = h; k = n - 1;
    for (int i = 1; i < n; i++)
      if (!m_found && dmod(l + m_dir * i) != rf) begin
        m_found = 1; m_res = l + m_dir * i; k = i;
      end
    m_L = 1 + (k + 1) * STEP;
  endtask

  // Compares every DUT output of u_a in cycle cyc, then drives cmp_in for that cycle.
  task automatic cmp_cycle();
    bit act, ep, d;
    int code_now;
    act = (cyc < m_L);
    code_now = m_lo + m_dir * ((cyc - 1) / STEP);
    chk("busy", a_busy, 1);
    chk("res_valid", a_valid, !act);
    if (!act) begin
      chk("res_code", a_code, m_res);
      chk("res_found", a_found, m_found);
    end
    ep = act && ((m_tot % 256) + code_now >= 256);
    chk("dac_p", a_p, (act && ep) ? (1 << m_sel) : 0);
    chk("dac_m", a_m, (act && !ep) ? (1 << m_sel) : 0);
    if (act) m_tot += code_now;
    d = dmod(code_now) ^ (cyc == m_gl);
    a_cmp = m_sel ? {d, ~d} : {~d, d};
  endtask

  task automatic run_a(input int l, input int h, input int sel, input int mode, input int thr,
                       input int gl, input int hold, input bit pulse,
                       input int exp_lat, input int exp_code, input bit exp_found);
    int first_v;
    bit done;
    model_setup(l, h, sel, mode, thr, gl);
    @(negedge clk);
    lo = 8'(l); hi = 8'(h); a_sel = 1'(sel); a_start = 1'b1; a_ready = 1'b0;
    first_v = 0; done = 0;
    for (int c = 1; c < m_L + hold + 20 && !done; c++) begin
      @(negedge clk);
      cyc = c;
      lo = 8'h5A; hi = 8'hA5; a_sel = ~1'(sel);  // latched copies must be used
      cmp_cycle();
      a_start = pulse && (c == 2);
      if (a_valid && first_v == 0) first_v = c;
      if (a_valid && c >= m_L + hold) begin
        a_ready = 1'b1;
        a_start = 1'b1;  // lands on the handshake cycle and must not be queued
        done = 1;
      end
    end
    if (!done) $display("FAIL timeout: got no result expected res_valid by cycle %0d", m_L + hold);
    chk("latency", first_v, exp_lat);
    chk("lit_code", a_code, exp_code);
    chk("lit_found", a_found, exp_found);
    @(negedge clk);
    a_ready = 1'b0; a_start = 1'b0;
    chk("busy_after_hs", a_busy, 0);
    chk("valid_after_hs", a_valid, 0);
    repeat (3) @(negedge clk);
    chk("no_second_sweep", a_busy, 0);
  endtask

  initial begin
    int ones, mism, stray, first_v;
    repeat (2) @(negedge clk);
    chk("rst_busy", a_busy, 0);
    chk("rst_valid", a_valid, 0);
    chk("rst_code", a_code, 0);
    chk("rst_found", a_found, 0);
    chk("rst_dac", {a_p, a_m, b_p, b_m}, 0);
    chk("rst_b_busy", b_busy, 0);
    rst_n = 1'b1;

    run_a(8'h00, 8'hFF, 0, 1, 8'h40, 0, 0, 1'b0, (SL == 1) ? 326 : 456, 8'h40, 1'b1);
    run_a(8'h80, 8'h10, 1, 0, 0, 0, 0, 1'b0, (SL == 1) ? 566 : 792, 8'h10, 1'b0);
    run_a(8'h30, 8'h20, 0, 1, 8'h28, 0, 10, 1'b1, (SL == 1) ? 51 : 71, 8'h27, 1'b1);

    // Reset mid-SETTLE clears the held result of the previous sweep.
    @(negedge clk);
    lo = 8'h00; hi = 8'hFF; a_sel = 1'b0; a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst_busy", a_busy, 0);
    chk("mid_rst_valid", a_valid, 0);
    chk("mid_rst_dac", {a_p, a_m}, 0);
    chk("mid_rst_code", a_code, 0);
    chk("mid_rst_found", a_found, 0);
    run_a(8'h33, 8'h33, 1, 1, 0, 0, 0, 1'b0, 1 + STEP, 8'h33, 1'b0);

`ifdef DAC_COMP_SWEEP_AVG_EN
    // One-cycle glitch on the first capture of the code 0x20 sample window.
    run_a(8'h00, 8'hFF, 0, 1, 8'h40, 5 + 7 * 32, 0, 1'b0, 456, 8'h40, 1'b1);
`endif

    // Long settle on channel 1: bitstream density 64/256.
    @(negedge clk);
    lo = 8'h40; hi = 8'h40; b_sel = 2'd1; b_start = 1'b1;
    ones = 0; mism = 0; stray = 0; first_v = 0;
    for (int c = 1; c <= 256 + SL + 20 && first_v == 0; c++) begin
      @(negedge clk);
      b_start = 1'b0;
      if (c <= 256) begin
        ones += int'(b_p[1]);
        if (b_m[1] !== ~b_p[1]) mism++;
        if ({b_p[0], b_m[0], b_p[2], b_m[2]} !== 4'b0000) stray++;
      end
      if (b_valid) first_v = c;
    end
    chk("b_ones", ones, 64);
    chk("b_complement", mism, 0);
    chk("b_other_ch", stray, 0);
    chk("b_latency", first_v, 1 + 256 + SL);
    chk("b_code", b_code, 8'h40);
    chk("b_found", b_found, 0);
    b_ready = 1'b1;
    @(negedge clk);
    b_ready = 1'b0;
    chk("b_busy_after_hs", b_busy, 0);

    // Out-of-range channel reports immediately.
    lo = 8'h5A; hi = 8'h99; b_sel = 2'd3; b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    chk("oor_valid", b_valid, 1);
    chk("oor_busy", b_busy, 1);
    chk("oor_code", b_code, 8'h5A);
    chk("oor_found", b_found, 0);
    chk("oor_dac", {b_p, b_m}, 0);
    b_ready = 1'b1;
    @(negedge clk);
    b_ready = 1'b0;
    chk("oor_valid_after_hs", b_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dac_comp_sweep.md
# dac_comp_sweep

Parametrised digital-DAC / digital-comparator characterisation engine. It drives one of `CH` comparator channels with a first-order sigma-delta DAC bitstream pair (P/M). It sweeps the DAC code between two programmable endpoints and reports the code at which the selected comparator's decision first flips. It sits between the tile wrapper pins and the cell-based comparators (NAND, AO22, MX21 variants). It replaces the free-running external-clock counters with a single-clock, handshaked sweep.

## Interface
Parameters:
- `WIDTH`, default 8: DAC code width.
- `CH`, default 2: comparator channel count. Must be ≥2.
- `SETTLE`, default 4: settle cycles per step. Must be ≥1.

Ports:
- `clk`  in  1  single clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  sweep request. Sampled only in IDLE.
- `ch_sel`  in  $clog2(CH)  channel under test. Latched on start.
- `code_lo`  in  WIDTH  first code. Latched on start.
- `code_hi`  in  WIDTH  last code, inclusive. Latched on start.
- `cmp_in`  in  CH  comparator decisions, one per channel.
- `dac_p`  out  CH  sigma-delta bitstream per channel.
- `dac_m`  out  CH  complement bitstream per channel.
- `busy`  out  1  high from the cycle after an accepted start until REPORT is exited.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  result consumed.
- `res_code`  out  WIDTH  trip code, or the last code if no trip occurred.
- `res_found`  out  1  1 = comparator flipped during the sweep.

## Operation
- Direction is fixed at start:
  - up when `code_lo` ≤ `code_hi`;
  - down otherwise.
  - Step size is ±1. The code never wraps. The sweep ends after the step at `code_hi`.
- DAC:
  - WIDTH-bit accumulator. Each cycle, acc ← acc[WIDTH-1:0] + code; carry → `dac_p[ch]`, and `dac_m[ch]` = ~carry.
  - Density is code/2^WIDTH. The accumulator is cleared only by reset and on start.
  - In non-selected channels, and in any state other than SETTLE/SAMPLE, `dac_p` = `dac_m` = 0.
- FSM states are IDLE, SETTLE, SAMPLE and REPORT.
- IDLE:
  - On `start`, latch the inputs and set code ← `code_lo`.
  - Go to SETTLE. If `ch_sel` ≥ CH, go to REPORT instead with found = 0 and `res_code` = `code_lo`.
- SETTLE: count `SETTLE` cycles, then go to SAMPLE.
- SAMPLE: capture the decision d = `cmp_in[ch_sel]`.
  - On the first step, store the reference ref ← d.
  - On later steps, if d ≠ ref: `res_found` = 1, `res_code` = current code, go to REPORT.
  - Else, if code = `code_hi`: `res_found` = 0, `res_code` = `code_hi`, go to REPORT.
  - Else, step the code and go to SETTLE.
- REPORT:
  - `res_valid` = 1. `res_code` and `res_found` are held stable.
  - When `res_valid` and `res_ready` are both high, go to IDLE. `res_valid` is 0 the next cycle.
- `start` while `busy` is ignored. A `start` in the same cycle as the REPORT handshake is ignored; it is not queued.
- With `code_lo` = `code_hi`, the sweep is one step, and the result is `res_found` = 0, `res_code` = `code_lo`.

## Timing
- Reset (`rst_n` low at a clk edge) gives: state IDLE, accumulator 0, all `dac_p`/`dac_m` 0, `busy` 0, `res_valid` 0, `res_code` 0, `res_found` 0. This applies from any state, including mid-sweep.
- `start` accepted at edge 0 → `busy` = 1 and SETTLE at cycle 1.
- Each step lasts `SETTLE` + 1 cycles (SETTLE cycles plus one SAMPLE cycle).
- A result decided at step k (k = 0 is the first code) gives `res_valid` rising at cycle 1 + (k+1)·(SETTLE+1).
- The out-of-range `ch_sel` case gives `res_valid` at cycle 1.
- `cmp_in` is treated as synchronous to clk. The bench drives it with setup to clk. Synchronisation is the wrapper's job.

## Configuration
- `DAC_COMP_SWEEP_AVG_EN` defined:
  - SAMPLE lasts 3 cycles and d = majority of the 3 captures.
  - Step length is `SETTLE` + 3 cycles, and the latency formula uses SETTLE+3.
- Undefined: single-cycle SAMPLE as above.

## Test plan
- Defaults; `code_lo`=0x00, `code_hi`=0xFF, `ch_sel`=0, model `cmp_in[0]` = (code ≥ 0x40) → `res_found`=1, `res_code`=0x40, `res_valid` rises at cycle 326.
- `SETTLE`=256, `code_lo`=`code_hi`=0x40, `ch_sel`=1 → `dac_p[1]` high for exactly 64 of the 256 SETTLE cycles and `dac_m[1]` is its complement; `dac_p[0]`=`dac_m[0]`=0; result `res_found`=0, `res_code`=0x40.
- `code_lo`=0x80, `code_hi`=0x10, `cmp_in` tied 0 → down-sweep of 113 steps; `res_found`=0, `res_code`=0x10, `res_valid` at cycle 566.
- Hold `res_ready` low for 10 cycles in REPORT and pulse `start` during `busy` → `res_valid`, `res_code`, `res_found` stay constant; no second sweep; `busy` falls the cycle after the handshake.
- Drive `rst_n` low for one cycle mid-SETTLE → next cycle `busy`=0, all `dac_*`=0, `res_valid`=0; a new start then completes normally.
- With `DAC_COMP_SWEEP_AVG_EN`: a 1-cycle glitch on `cmp_in` during SAMPLE is ignored, and the true trip at 0x40 is still reported, at cycle 1 + 65·7 = 456.
